// File: rtl/seg_display_decoder_if.sv
// seg_display_decoder_if
// Multiplexed 7-segment display bus plus the decoded-value outputs of the
// display monitor. The master drives the segment/anode lines (display
// controller or bench); the slave is the decoder watching them.
interface seg_display_decoder_if;
   logic [6:0] seg;          // active-low segments, bit 6 = g ... bit 0 = a
   logic [3:0] an;           // active-low anodes, [0] units ... [3] sign
   logic [7:0] value_out;    // last good decoded value, two's complement
   logic       value_valid;  // one-cycle pulse on value_out update
   logic       frame_error;  // one-cycle pulse on a malformed frame
   logic       stale;        // no completed frame for FRAME_TIMEOUT cycles

   modport master (
      output seg,
      output an,
      input  value_out,
      input  value_valid,
      input  frame_error,
      input  stale
   );

   modport slave (
      input  seg,
      input  an,
      output value_out,
      output value_valid,
      output frame_error,
      output stale
   );
endinterface

// File: rtl/seg_display_decoder.sv
// seg_display_decoder
// Watches a multiplexed common-anode 7-segment bus laid out as
// sign / hundreds / tens / units, captures each digit once per anode dwell
// once the anodes have been stable for SETTLE_CYCLES, and decodes a frame
// into a signed 8-bit value when all four digits have been captured.
// Optional build macro: DISP_DEC_CHANGE_ONLY_EN -- when defined, value_valid
// pulses only for a good frame whose value differs from value_out, or for
// the first good frame after reset.
module seg_display_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned FRAME_TIMEOUT = 2_000_000
) (
   input logic                  clk,
   input logic                  reset,
   seg_display_decoder_if.slave bus
);

   localparam int unsigned TO_W = (FRAME_TIMEOUT == 0) ? 1 : $clog2(FRAME_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX    = TO_W'(FRAME_TIMEOUT);
   localparam logic [7:0]      STAB_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0]      STAB_LAST = 8'(SETTLE_CYCLES - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] DIGIT_CODE [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef enum logic [1:0] {
      SYM_DIGIT,
      SYM_MINUS,
      SYM_BLANK,
      SYM_BAD
   } sym_kind_e;

   // Classify one captured segment pattern.
   function automatic sym_kind_e kind_of(input logic [6:0] s);
      sym_kind_e k;
      if (s == SEG_MINUS) begin
         k = SYM_MINUS;
      end else if (s == SEG_BLANK) begin
         k = SYM_BLANK;
      end else begin
         k = SYM_BAD;
      end
      for (int unsigned i = 0; i < 10; i++) begin
         if (s == DIGIT_CODE[i]) begin
            k = SYM_DIGIT;
         end
      end
      return k;
   endfunction

   // Numeric value of a digit pattern; 0 for anything that is not a digit.
   function automatic logic [3:0] digit_val(input logic [6:0] s);
      logic [3:0] v;
      v = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (s == DIGIT_CODE[i]) begin
            v = 4'(i);
         end
      end
      return v;
   endfunction

   // state
   logic [3:0]      an_q;
   logic [7:0]      stab_cnt;
   logic [6:0]      slot [4];
   logic [3:0]      mask;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      value_q;
   logic            vv_q;
   logic            fe_q;
`ifdef DISP_DEC_CHANGE_ONLY_EN
   logic            seen_q;
`endif

   // combinational
   logic            an_valid;
   logic [1:0]      an_sel;
   logic [7:0]      stab_nxt;
   logic            capture;
   logic [6:0]      slot_nxt [4];
   logic [3:0]      mask_nxt;
   logic            frame_done;
   logic            frame_err;
   logic [7:0]      frame_val;

   // Anode decode: exactly one active-low bit selects a digit slot.
   always_comb begin
      an_valid = 1'b0;
      an_sel   = 2'd0;
      case (bus.an)
         4'b1110: begin an_valid = 1'b1; an_sel = 2'd0; end
         4'b1101: begin an_valid = 1'b1; an_sel = 2'd1; end
         4'b1011: begin an_valid = 1'b1; an_sel = 2'd2; end
         4'b0111: begin an_valid = 1'b1; an_sel = 2'd3; end
         default: begin an_valid = 1'b0; an_sel = 2'd0; end
      endcase
   end

   // Stability counter; capture fires only on the edge it reaches SETTLE_CYCLES,
   // so a long dwell yields one capture and then sits saturated.
   always_comb begin
      stab_nxt = '0;
      capture  = 1'b0;
      if (an_valid && (bus.an == an_q)) begin
         if (stab_cnt == STAB_MAX) begin
            stab_nxt = stab_cnt;
         end else begin
            stab_nxt = stab_cnt + 8'd1;
         end
         capture = (stab_cnt == STAB_LAST);
      end
   end

   // Slot and mask update for this cycle's capture; the frame completes when
   // the updated mask is full.
   always_comb begin
      slot_nxt = slot;
      mask_nxt = mask;
      if (capture) begin
         slot_nxt[an_sel] = bus.seg;
         mask_nxt[an_sel] = 1'b1;
      end
      frame_done = capture && (mask_nxt == 4'b1111);
   end

   // Frame decode from the post-capture slot contents.
   always_comb begin
      sym_kind_e  s_kind;
      sym_kind_e  h_kind;
      sym_kind_e  t_kind;
      sym_kind_e  u_kind;
      logic [3:0] h_dig;
      logic [3:0] t_dig;
      logic [3:0] u_dig;
      logic [9:0] mag;
      logic       neg;

      s_kind = kind_of(slot_nxt[3]);
      h_kind = kind_of(slot_nxt[2]);
      t_kind = kind_of(slot_nxt[1]);
      u_kind = kind_of(slot_nxt[0]);
      h_dig  = '0;
      t_dig  = '0;
      u_dig  = digit_val(slot_nxt[0]);
      neg       = 1'b0;
      frame_err = 1'b0;

      case (s_kind)
         SYM_MINUS: neg = 1'b1;
         SYM_BLANK: neg = 1'b0;
         default:   frame_err = 1'b1;
      endcase

      case (h_kind)
         SYM_DIGIT: h_dig = digit_val(slot_nxt[2]);
         SYM_BLANK: h_dig = '0;
         default:   frame_err = 1'b1;
      endcase

      case (t_kind)
         SYM_DIGIT: t_dig = digit_val(slot_nxt[1]);
         SYM_BLANK: t_dig = '0;
         default:   frame_err = 1'b1;
      endcase

      if (u_kind != SYM_DIGIT) begin
         frame_err = 1'b1;
      end

      mag = 10'(h_dig) * 10'd100 + 10'(t_dig) * 10'd10 + 10'(u_dig);

      // -128 is representable, +128 is not
      if (neg ? (mag > 10'd128) : (mag > 10'd127)) begin
         frame_err = 1'b1;
      end

      frame_val = neg ? (8'd0 - mag[7:0]) : mag[7:0];
   end

   // Registered state: anode tracking, captures, frame results and timeout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         an_q     <= '1;
         stab_cnt <= '0;
         slot     <= '{default: SEG_BLANK};
         mask     <= '0;
         to_cnt   <= '0;
         value_q  <= '0;
         vv_q     <= 1'b0;
         fe_q     <= 1'b0;
`ifdef DISP_DEC_CHANGE_ONLY_EN
         seen_q   <= 1'b0;
`endif
      end else begin
         an_q     <= bus.an;
         stab_cnt <= stab_nxt;
         slot     <= slot_nxt;
         vv_q     <= 1'b0;
         fe_q     <= 1'b0;
         if (frame_done) begin
            mask   <= '0;
            to_cnt <= '0;
            if (frame_err) begin
               fe_q <= 1'b1;
            end else begin
               value_q <= frame_val;
`ifdef DISP_DEC_CHANGE_ONLY_EN
               vv_q    <= !seen_q || (frame_val != value_q);
               seen_q  <= 1'b1;
`else
               vv_q    <= 1'b1;
`endif
            end
         end else begin
            mask <= mask_nxt;
            if (to_cnt != TO_MAX) begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
      end
   end

   assign bus.value_out   = value_q;
   assign bus.value_valid = vv_q;
   assign bus.frame_error = fe_q;
   assign bus.stale       = (to_cnt >= TO_MAX);

endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder
// Directed scans of the display bus; a frame-level reference model predicts
// value_out / value_valid / frame_error / stale on every cycle, and literal
// hand-computed expectations pin key results. Build with
// DISP_DEC_CHANGE_ONLY_EN defined to exercise the change-only variant.
module tb_seg_display_decoder;
   localparam int S  = 4;
   localparam int FT = 300;

   localparam logic [6:0] BLK = 7'b1111111;
   localparam logic [6:0] MIN = 7'b0111111;
   localparam logic [6:0] BAD = 7'b1010101;
   localparam logic [6:0] DIG [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

`ifdef DISP_DEC_CHANGE_ONLY_EN
   localparam int FINAL_VV = 6;
`else
   localparam int FINAL_VV = 7;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   edge_n = 0;
   logic rst_seen = 1'b0;

   seg_display_decoder_if dif ();

   seg_display_decoder #(
      .SETTLE_CYCLES (S),
      .FRAME_TIMEOUT (FT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      edge_n   <= edge_n + 1;
      rst_seen <= reset;
   end

   // scoreboard / counters (written only by the compare process)
   int errors = 0;
   int checks = 0;
   int vv_cnt = 0;
   int fe_cnt = 0;

   // capture schedule (written only by the stimulus process)
   int         cap_slot [int];
   logic [6:0] cap_pat  [int];
   int         last_cap_edge = 0;
   logic [3:0] prev_an = 4'hF;

   // literal-expectation request (written only by the stimulus process)
   bit    lit_valid = 1'b0;
   int    lit_kind  = 0;
   int    lit_exp   = 0;
   string lit_name  = "";

   // reference model state
   logic [6:0]  m_slot [4];
   logic [3:0]  m_mask;
   logic [7:0]  m_val;
   bit          m_vv;
   bit          m_fe;
   int          m_age;
   bit          m_seen;

   function automatic int sym(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (p == DIG[i]) return i;
      end
      if (p == MIN) return -1;
      if (p == BLK) return -2;
      return -3;
   endfunction

   function automatic int slot_of(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
      end
   endtask

   // Compare process: advance the model by one edge, then check the DUT.
   always @(negedge clk) begin
      int s, h, t, u, m;
      bit neg, err;
      logic [7:0] nv;
      if (!rst_seen) begin
         for (int i = 0; i < 4; i++) m_slot[i] = BLK;
         m_mask = '0;
         m_val  = '0;
         m_vv   = 1'b0;
         m_fe   = 1'b0;
         m_age  = 0;
         m_seen = 1'b0;
      end else begin
         m_vv = 1'b0;
         m_fe = 1'b0;
         if (m_age < FT) m_age++;
         if (cap_slot.exists(edge_n)) begin
            m_slot[cap_slot[edge_n]] = cap_pat[edge_n];
            m_mask[cap_slot[edge_n]] = 1'b1;
            if (m_mask == 4'hF) begin
               s = sym(m_slot[3]);
               h = sym(m_slot[2]);
               t = sym(m_slot[1]);
               u = sym(m_slot[0]);
               err = 1'b0;
               m   = 0;
               neg = (s == -1);
               if (s != -1 && s != -2) err = 1'b1;
               if (h == -2) h = 0; else if (h < 0) err = 1'b1;
               if (t == -2) t = 0; else if (t < 0) err = 1'b1;
               if (u < 0) err = 1'b1;
               if (!err) begin
                  m = h * 100 + t * 10 + u;
                  if (m > (neg ? 128 : 127)) err = 1'b1;
               end
               if (err) begin
                  m_fe = 1'b1;
               end else begin
                  nv = 8'(neg ? -m : m);
`ifdef DISP_DEC_CHANGE_ONLY_EN
                  m_vv   = !m_seen || (nv != m_val);
                  m_seen = 1'b1;
`else
                  m_vv = 1'b1;
`endif
                  m_val = nv;
               end
               m_mask = '0;
               m_age  = 0;
            end
         end
      end

      chk("value_out",   dif.value_out, m_val);
      chk("value_valid", {7'b0, dif.value_valid}, {7'b0, m_vv});
      chk("frame_error", {7'b0, dif.frame_error}, {7'b0, m_fe});
      chk("stale",       {7'b0, dif.stale}, {7'b0, (m_age >= FT)});

      if (dif.value_valid === 1'b1) vv_cnt++;
      if (dif.frame_error === 1'b1) fe_cnt++;

      if (lit_valid) begin
         case (lit_kind)
            0:       chk(lit_name, dif.value_out, 8'(lit_exp));
            1:       chk(lit_name, {7'b0, dif.stale}, 8'(lit_exp));
            2:       chk(lit_name, 8'(vv_cnt), 8'(lit_exp));
            default: chk(lit_name, 8'(fe_cnt), 8'(lit_exp));
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      lit_valid = 1'b0;
   endtask

   // Check state after the most recent edge; 0 value_out, 1 stale,
   // 2 value_valid pulse count, 3 frame_error pulse count.
   task automatic lit(input int kind, input int exp, input string name);
      lit_kind  = kind;
      lit_exp   = exp;
      lit_name  = name;
      lit_valid = 1'b1;
      step();
   endtask

   // Hold an/seg for len edges; schedule the capture the decoder must make.
   task automatic dwell(input logic [3:0] a, input logic [6:0] p, input int len);
      int idx;
      idx = slot_of(a);
      dif.an  = a;
      dif.seg = p;
      if (idx >= 0 && a != prev_an && len >= S + 1) begin
         cap_slot[edge_n + 1 + S] = idx;
         cap_pat[edge_n + 1 + S]  = p;
         last_cap_edge = edge_n + 1 + S;
      end
      prev_an = a;
      repeat (len) step();
   endtask

   task automatic frame(input logic [6:0] sg, input logic [6:0] hd, input logic [6:0] td,
                        input logic [6:0] ud, input int len);
      dwell(4'b1110, ud, len);
      dwell(4'b1101, td, len);
      dwell(4'b1011, hd, len);
      dwell(4'b0111, sg, len);
   endtask

   initial begin
      int done;
      dif.an  = 4'hF;
      dif.seg = BLK;
      reset   = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      step();
      lit(0, 0, "reset value_out");
      lit(1, 0, "reset stale");
      lit(2, 0, "reset no pulse");

      // positive value 42
      frame(BLK, BLK, DIG[4], DIG[2], 10);
      lit(0, 42, "value 42");
      lit(2, 1, "pulses after 42");

      // negative extreme and error frames
      frame(MIN, DIG[1], DIG[2], DIG[8], 10);
      lit(0, 128, "value -128");
      frame(MIN, DIG[1], DIG[2], DIG[9], 10);
      lit(3, 1, "errors after -129");
      lit(0, 128, "value held after -129");
      frame(BLK, BLK, BAD, DIG[1], 10);
      lit(3, 2, "errors after bad pattern");
      lit(0, 128, "value held after bad pattern");

      // glitches: short dwell, two anodes low, no anode
      dwell(4'hF, BLK, 2);
      dwell(4'b0111, MIN, S - 1);
      dwell(4'b1100, DIG[7], 10);
      dwell(4'hF, BLK, 10);
      lit(2, 2, "no pulse after glitches");
      lit(0, 128, "value after glitches");
      frame(BLK, DIG[1], DIG[2], DIG[7], S + 1);
      lit(0, 127, "value 127");
      lit(2, 3, "pulses after 127");

      // stale threshold
      done = last_cap_edge;
      dwell(4'hF, BLK, 1);
      while (edge_n < done + FT - 1) step();
      lit(1, 0, "stale one before threshold");
      lit(1, 1, "stale at threshold");
      frame(BLK, BLK, BLK, DIG[0], 10);
      lit(0, 0, "value 0");
      lit(1, 0, "stale cleared");
      lit(2, 4, "pulses after 0");

      // reset after two captures (sign, hundreds)
      dwell(4'hF, BLK, 2);
      dwell(4'b0111, BLK, 10);
      dwell(4'b1011, BLK, 10);
      dif.an  = 4'hF;
      dif.seg = BLK;
      prev_an = 4'hF;
      reset   = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      step();
      dwell(4'b1110, DIG[6], 10);
      dwell(4'b1101, DIG[3], 10);
      dwell(4'b1011, BLK, 10);
      lit(2, 4, "no pulse after 3 post-reset captures");
      lit(0, 0, "value after reset");
      dwell(4'b0111, BLK, 10);
      lit(0, 36, "value 36");
      lit(2, 5, "pulses after 36");

      // same frame twice
      frame(BLK, BLK, DIG[4], DIG[2], 10);
      frame(BLK, BLK, DIG[4], DIG[2], 10);
      lit(2, FINAL_VV, "pulses after repeated 42");
      lit(0, 42, "value repeated 42");
      lit(3, 2, "errors at end");

      step();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule

// File: doc/seg_display_decoder.md
# seg_display_decoder

Reads back the multiplexed common-anode 7-segment bus (`seg`/`an`) driven by `display_controller` and reconstructs the signed 8-bit value it is showing. It is the receiving end of the display interface. It sits beside the display controller in self-check builds, and in benches as a synthesizable display monitor. The digit layout is sign / hundreds / tens / units. The block samples each digit once per dwell and decodes a frame when all four digits have been captured. It emits the value, or flags a malformed frame.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive cycles `an` must hold before `seg` is sampled (range 1..255).
- `FRAME_TIMEOUT`, default 2_000_000: cycles without a completed frame before `stale` asserts.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `seg`  in  7  segment bus, active-low, bit 6 = g … bit 0 = a.
- `an`  in  4  anode bus, active-low; `an[0]` units, `an[1]` tens, `an[2]` hundreds, `an[3]` sign.
- `value_out`  out  8  last successfully decoded value, two's complement.
- `value_valid`  out  1  one-cycle pulse when `value_out` is updated.
- `frame_error`  out  1  one-cycle pulse when a completed frame fails decode.
- `stale`  out  1  level; no frame completed for `FRAME_TIMEOUT` cycles.

## Operation
**Anode tracking**
- `an_q` holds the previous `an`.
- `stab_cnt` clears when `an != an_q`; otherwise it increments, saturating at `SETTLE_CYCLES`.
- `an` is valid only if it has exactly one bit low. Invalid `an` (1111, or two or more lows) clears `stab_cnt` and captures nothing. It leaves the capture mask untouched.

**Capture**
- On the edge where `stab_cnt` reaches `SETTLE_CYCLES` with a valid `an`, `seg` is stored in the slot selected by `an`, and that slot's bit in `mask[3:0]` is set.
- Only one capture happens per dwell.
- Recapturing a slot before the frame completes overwrites it (latest wins).

**Pattern decode**, per slot:
- Digits 0–9 use the standard active-low codes, e.g. 1000000 = 0, 0100100 = 2, 0010000 = 9.
- 0111111 = minus.
- 1111111 = blank.
- Any other pattern is invalid.

**Frame decode**, triggered when `mask` becomes 1111:
- Sign slot: minus means negative, blank means positive. Anything else is an error.
- Hundreds and tens slots: a digit, or blank treated as 0. Minus or invalid is an error.
- Units slot: must be a digit.
- Magnitude M = H·100 + T·10 + U, computed in 10 bits (max 999).
- Range: positive requires M ≤ 127; negative requires M ≤ 128. Out of range is an error.
- Good frame: `value_out` ← +M or −M (8-bit), and `value_valid` pulses.
- Error frame: `frame_error` pulses and `value_out` holds.
- In both cases `mask` clears and the timeout counter clears.

**Stale**
- The timeout counter increments every cycle and saturates.
- `stale` = 1 when the counter ≥ `FRAME_TIMEOUT`.
- A completed frame, good or bad, clears the counter and `stale` together.

## Timing
- Reset (`reset` = 0 at an edge) sets: `value_out` = 0, `value_valid` = 0, `frame_error` = 0, `stale` = 0, `mask` = 0, counters = 0, slots = blank.
- Reset mid-frame discards all partial captures.
- Capture latency: `an` changes before edge E0; the capture happens at edge E(`SETTLE_CYCLES`).
- `value_valid`/`frame_error` assert for exactly one cycle, starting the cycle after the capture edge that completed the mask. `value_out` updates on the same edge.
- Completing capture and timeout saturation in the same cycle: the completion wins, so the counter clears.
- `value_valid` and `frame_error` are never high together.

## Configuration
- `DISP_DEC_CHANGE_ONLY_EN` defined: a good frame pulses `value_valid` only if the decoded value differs from the current `value_out`, or if it is the first good frame since reset.
- Not defined: every good frame pulses `value_valid`.
- `value_out` register contents are identical in both builds.

## Test plan
- **Positive value:** after reset, scan units '2', tens '4', hundreds blank, sign blank, each with a 10-cycle dwell. Required: `value_out` = 8'd42 and a single `value_valid` pulse, 1 cycle after the 4th capture.
- **Negative extreme and error frame:** scan '-','1','2','8'. Required: `value_out` = 8'h80. Then scan '-','1','2','9'. Required: a `frame_error` pulse and `value_out` stays 8'h80. Repeat with an invalid segment pattern 1010101; same error response required.
- **Glitches:** a dwell of `SETTLE_CYCLES`−1 cycles, `an` = 1100, and `an` = 1111 each produce no capture and no output change. A subsequent clean frame of 127 decodes to 8'd127.
- **Stale:** stop scanning (`an` = 1111) for `FRAME_TIMEOUT` cycles. Required: `stale` = 1 exactly at the threshold. Resume a '0' frame. Required: `stale` = 0 and `value_out` = 0.
- **Reset mid-frame:** assert reset after 2 captures, then release and scan 3 digits. Required: no pulse. The 4th capture then produces a pulse.
- **Change-only macro:** scan the 42 frame twice. With `DISP_DEC_CHANGE_ONLY_EN`: 1 `value_valid` pulse. Without it: 2 pulses.
